sg_uart_seq: RTL and testbench

SG_UART_SEQ -- requirements
Module: sg_uart_seq

---
 rtl/sg_uart_pkg.sv | 36 +++
 rtl/sg_apb_master.sv | 59 +++++
 rtl/sg_uart_seq.sv | 180 ++++++++++++++++++
 tb/tb_sg_uart_seq.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sg_uart_pkg.sv
// rtl/sg_uart_pkg.sv - UART register map, field constants and sequencer state encoding
package sg_uart_pkg;

  // APB word offsets (byte address [11:2]) of the UART registers
  localparam logic [9:0] REG_DATA    = 10'h000;
  localparam logic [9:0] REG_STATE   = 10'h001;
  localparam logic [9:0] REG_CTRL    = 10'h002;
  localparam logic [9:0] REG_BAUDDIV = 10'h004;

  // STATE register bit positions
  localparam int STATE_TX_FULL_BIT = 0;
  localparam int STATE_RX_FULL_BIT = 1;

  // CTRL register enable values
  localparam logic [31:0] CTRL_TX_EN = 32'h1;
  localparam logic [31:0] CTRL_RX_EN = 32'h2;

  // Sequencer personalities
  localparam int MODE_TX = 0;
  localparam int MODE_RX = 1;

  typedef enum logic [2:0] {
    ST_WAIT     = 3'd0,
    ST_CFG_BAUD = 3'd1,
    ST_CFG_CTRL = 3'd2,
    ST_POLL     = 3'd3,
    ST_XFER     = 3'd4,
    ST_FIN      = 3'd5
  } seq_state_t;

  // Pattern byte for a given byte index; 8-bit wrap, carry discarded
  function automatic logic [7:0] pattern_byte(input logic [7:0] seed, input logic [7:0] idx);
    return seed + idx;
  endfunction

endpackage

// File: rtl/sg_apb_master.sv
// rtl/sg_apb_master.sv - single-transfer APB master driven by a req/ack handshake
// Ports:
//   CLK, RESETn                         clock, async active-low reset
//   req, req_addr, req_write, req_wdata transfer request (level, held until ack)
//   ack, rdata                          one-cycle completion pulse and captured read data
//   PSEL, PADDR, PENABLE, PWRITE,
//   PWDATA, PRDATA, PREADY              APB bus
module sg_apb_master
  import sg_uart_pkg::*;
(
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        req,
  input  logic [9:0]  req_addr,
  input  logic        req_write,
  input  logic [31:0] req_wdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        PSEL,
  output logic [9:0]  PADDR,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY
);

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
      PWRITE  <= 1'b0;
      PADDR   <= '0;
      PWDATA  <= '0;
      ack     <= 1'b0;
      rdata   <= '0;
    end else begin
      ack <= 1'b0;
      if (PSEL && PENABLE) begin
        if (PREADY) begin
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
          ack     <= 1'b1;
          rdata   <= PRDATA;
        end
      end else if (PSEL) begin
        PENABLE <= 1'b1;
      end else if (req && !ack) begin
        // The ack cycle doubles as the mandatory idle cycle and lets the
        // requester swap in the next address before a new setup begins.
        PSEL   <= 1'b1;
        PADDR  <= req_addr;
        PWRITE <= req_write;
        PWDATA <= req_wdata;
      end
    end
  end

endmodule

// File: rtl/sg_uart_seq.sv
// rtl/sg_uart_seq.sv - UART transmit / receive-and-check sequencer over APB
// Ports:
//   CLK, RESETn                   clock, async active-low reset
//   PSEL..PREADY                  APB master port to the UART
//   DONE                          sticky run-complete flag
//   TIMEOUT                       sticky poll-limit-exceeded flag
//   BYTE_CNT                      bytes transferred this run
//   ERR_CNT                       receive compare mismatches, saturating
module sg_uart_seq
  import sg_uart_pkg::*;
#(
  parameter int         MODE        = 0,
  parameter int         NUM_BYTES   = 16,
  parameter int         BAUDDIV     = 16,
  parameter logic [7:0] SEED        = 8'h41,
  parameter int         START_DELAY = 16,
  parameter int         POLL_LIMIT  = 65535
) (
  input  logic        CLK,
  input  logic        RESETn,
  output logic        PSEL,
  output logic [9:0]  PADDR,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  output logic        DONE,
  output logic        TIMEOUT,
  output logic [15:0] BYTE_CNT,
  output logic [15:0] ERR_CNT
);

  if (MODE != MODE_TX && MODE != MODE_RX) begin : g_bad_mode
    $error("sg_uart_seq: MODE must be 0 or 1");
  end
  if (NUM_BYTES < 1 || NUM_BYTES > 65535) begin : g_bad_num_bytes
    $error("sg_uart_seq: NUM_BYTES out of range 1..65535");
  end
  if (BAUDDIV < 16 || BAUDDIV > 1048575) begin : g_bad_bauddiv
    $error("sg_uart_seq: BAUDDIV out of range 16..2^20-1");
  end
  if (POLL_LIMIT < 1 || POLL_LIMIT > 65535) begin : g_bad_poll_limit
    $error("sg_uart_seq: POLL_LIMIT out of range 1..65535");
  end

  localparam bit          IS_RX        = (MODE == MODE_RX);
  localparam logic [31:0] CTRL_VAL     = IS_RX ? CTRL_RX_EN : CTRL_TX_EN;
  localparam logic [31:0] BAUD_VAL     = 32'(BAUDDIV);
  localparam logic [15:0] LAST_BYTE    = 16'(NUM_BYTES - 1);
  localparam logic [15:0] LAST_POLL    = 16'(POLL_LIMIT - 1);
  localparam logic [31:0] START_CYCLES = 32'(START_DELAY);

  seq_state_t  state;
  logic [31:0] wait_cnt;
  logic [15:0] poll_cnt;
  logic        req;
  logic [9:0]  req_addr;
  logic        req_write;
  logic [31:0] req_wdata;
  logic        ack;
  logic [31:0] rdata;
  logic [7:0]  pattern;
  logic        polled_ok;
  logic        unused_rdata_hi;

  assign pattern         = pattern_byte(SEED, BYTE_CNT[7:0]);
  assign polled_ok       = IS_RX ? rdata[STATE_RX_FULL_BIT] : !rdata[STATE_TX_FULL_BIT];
  assign unused_rdata_hi = ^rdata[31:8];

  sg_apb_master u_apb (
    .CLK       (CLK),
    .RESETn    (RESETn),
    .req       (req),
    .req_addr  (req_addr),
    .req_write (req_write),
    .req_wdata (req_wdata),
    .ack       (ack),
    .rdata     (rdata),
    .PSEL      (PSEL),
    .PADDR     (PADDR),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY)
  );

  // Each state holds req high with its transfer parameters; on ack the next
  // transfer's parameters are loaded in the same edge.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state     <= ST_WAIT;
      wait_cnt  <= '0;
      poll_cnt  <= '0;
      req       <= 1'b0;
      req_addr  <= '0;
      req_write <= 1'b0;
      req_wdata <= '0;
      DONE      <= 1'b0;
      TIMEOUT   <= 1'b0;
      BYTE_CNT  <= '0;
      ERR_CNT   <= '0;
    end else begin
      case (state)
        ST_WAIT: begin
          if (wait_cnt >= START_CYCLES) begin
            state     <= ST_CFG_BAUD;
            req       <= 1'b1;
            req_addr  <= REG_BAUDDIV;
            req_write <= 1'b1;
            req_wdata <= BAUD_VAL;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        ST_CFG_BAUD: begin
          if (ack) begin
            state     <= ST_CFG_CTRL;
            req_addr  <= REG_CTRL;
            req_wdata <= CTRL_VAL;
          end
        end
        ST_CFG_CTRL: begin
          if (ack) begin
            state     <= ST_POLL;
            req_addr  <= REG_STATE;
            req_write <= 1'b0;
            req_wdata <= '0;
          end
        end
        ST_POLL: begin
          if (ack) begin
            if (polled_ok) begin
              poll_cnt  <= '0;
              state     <= ST_XFER;
              req_addr  <= REG_DATA;
              req_write <= !IS_RX;
              req_wdata <= {24'h0, pattern};
            end else if (poll_cnt == LAST_POLL) begin
              TIMEOUT <= 1'b1;
              DONE    <= 1'b1;
              req     <= 1'b0;
              state   <= ST_FIN;
            end else begin
              poll_cnt <= poll_cnt + 16'd1;
            end
          end
        end
        ST_XFER: begin
          if (ack) begin
            // BYTE_CNT still holds this byte's index, so pattern is current
            if (IS_RX && rdata[7:0] != pattern && ERR_CNT != 16'hFFFF) begin
              ERR_CNT <= ERR_CNT + 16'd1;
            end
            BYTE_CNT <= BYTE_CNT + 16'd1;
            if (BYTE_CNT == LAST_BYTE) begin
              DONE  <= 1'b1;
              req   <= 1'b0;
              state <= ST_FIN;
            end else begin
              state     <= ST_POLL;
              req_addr  <= REG_STATE;
              req_write <= 1'b0;
              req_wdata <= '0;
            end
          end
        end
        ST_FIN: begin
          req <= 1'b0;
        end
        default: begin
          state <= ST_WAIT;
          req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sg_uart_seq.sv
// tb/tb_sg_uart_seq.sv - scoreboard bench for a TX and an RX sequencer against a UART model
`timescale 1ns/1ps
module tb_sg_uart_seq;

  localparam int TX_NB   = 5;
  localparam int TX_BAUD = 16;
  localparam int TX_SEED = 8'hFE;
  localparam int RX_NB   = 6;
  localparam int RX_BAUD = 'h3A7;
  localparam int RX_SEED = 8'h41;
  localparam int RX_PL   = 8;

  typedef struct packed {
    logic [9:0]  addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        psel[2], penable[2], pwrite[2], pready[2], done[2], timeout[2];
  logic [9:0]  paddr[2];
  logic [31:0] pwdata[2], prdata[2];
  logic [15:0] byte_cnt[2], err_cnt[2];

  txn_t q0[$];
  txn_t q1[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   exp_err[2];
  int   exp_bytes[2];
  bit   exp_to[2];
  bit   force_waits = 1'b0;

  // Per-instance UART model state
  bit          busy[2];
  bit          gap_chk[2];
  int          waits_left[2];
  int          waits_sel[2];
  int          en_cycles[2];
  logic [9:0]  s_addr[2];
  logic        s_wr[2];
  logic [31:0] s_wd[2];
  logic        prev_done[2];
  logic        prev_to[2];

  sg_uart_seq #(.MODE(0), .NUM_BYTES(TX_NB), .BAUDDIV(TX_BAUD), .SEED(8'hFE),
                .START_DELAY(16), .POLL_LIMIT(65535)) u_tx (
    .CLK(clk), .RESETn(rst_n),
    .PSEL(psel[0]), .PADDR(paddr[0]), .PENABLE(penable[0]), .PWRITE(pwrite[0]),
    .PWDATA(pwdata[0]), .PRDATA(prdata[0]), .PREADY(pready[0]),
    .DONE(done[0]), .TIMEOUT(timeout[0]), .BYTE_CNT(byte_cnt[0]), .ERR_CNT(err_cnt[0])
  );

  sg_uart_seq #(.MODE(1), .NUM_BYTES(RX_NB), .BAUDDIV(RX_BAUD), .SEED(8'h41),
                .START_DELAY(5), .POLL_LIMIT(RX_PL)) u_rx (
    .CLK(clk), .RESETn(rst_n),
    .PSEL(psel[1]), .PADDR(paddr[1]), .PENABLE(penable[1]), .PWRITE(pwrite[1]),
    .PWDATA(pwdata[1]), .PRDATA(prdata[1]), .PREADY(pready[1]),
    .DONE(done[1]), .TIMEOUT(timeout[1]), .BYTE_CNT(byte_cnt[1]), .ERR_CNT(err_cnt[1])
  );

  task automatic check(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got %0h, expected %0h", name, inst, act, exp);
  endtask

  function automatic txn_t mk(input logic [9:0] a, input logic w, input logic [31:0] wd,
                              input logic [31:0] rd);
    txn_t t;
    t.addr = a; t.wr = w; t.wdata = wd; t.rdata = rd;
    return t;
  endfunction

  task automatic push(input int i, input txn_t t);
    if (i == 0) q0.push_back(t);
    else q1.push_back(t);
  endtask

  // Expected bus traffic for one run of both sequencers, with the UART's
  // answers attached to each read.
  task automatic plan_run(input bit rx_timeout);
    logic [31:0] r;
    logic [7:0]  pat, d;
    int          f;
    push(0, mk(10'h004, 1'b1, TX_BAUD, 32'h0));
    push(0, mk(10'h002, 1'b1, 32'h1, 32'h0));
    for (int b = 0; b < TX_NB; b++) begin
      f = $urandom_range(0, 3);
      for (int k = 0; k < f; k++) begin
        r = $urandom; push(0, mk(10'h001, 1'b0, 32'h0, r | 32'h1));
      end
      r = $urandom; push(0, mk(10'h001, 1'b0, 32'h0, r & ~32'h1));
      pat = 8'((TX_SEED + b) % 256);
      push(0, mk(10'h000, 1'b1, {24'h0, pat}, 32'h0));
    end
    exp_bytes[0] = TX_NB; exp_err[0] = 0; exp_to[0] = 1'b0;

    push(1, mk(10'h004, 1'b1, RX_BAUD, 32'h0));
    push(1, mk(10'h002, 1'b1, 32'h2, 32'h0));
    exp_err[1] = 0;
    if (rx_timeout) begin
      for (int k = 0; k < RX_PL; k++) begin
        r = $urandom; push(1, mk(10'h001, 1'b0, 32'h0, r & ~32'h2));
      end
      exp_bytes[1] = 0; exp_to[1] = 1'b1;
    end else begin
      for (int b = 0; b < RX_NB; b++) begin
        f = ($urandom_range(0, 3) == 0) ? RX_PL - 1 : int'($urandom_range(0, 2));
        for (int k = 0; k < f; k++) begin
          r = $urandom; push(1, mk(10'h001, 1'b0, 32'h0, r & ~32'h2));
        end
        r = $urandom; push(1, mk(10'h001, 1'b0, 32'h0, r | 32'h2));
        pat = 8'((RX_SEED + b) % 256);
        d = pat;
        if ($urandom_range(0, 3) == 0) begin
          d = pat ^ 8'($urandom_range(1, 255));
          exp_err[1]++;
        end
        r = $urandom; push(1, mk(10'h000, 1'b0, 32'h0, {r[31:8], d}));
      end
      exp_bytes[1] = RX_NB; exp_to[1] = 1'b0;
    end
  endtask

  // Completing access: pop the scoreboard, compare, and return the planned read data
  task automatic complete(input int i);
    txn_t e;
    bit   have;
    have = 1'b0;
    if (i == 0) begin
      if (q0.size() > 0) begin have = 1'b1; e = q0.pop_front(); end
    end else begin
      if (q1.size() > 0) begin have = 1'b1; e = q1.pop_front(); end
    end
    check("txn_expected", i, {31'h0, have}, 32'h1);
    if (have) begin
      check("paddr", i, {22'h0, paddr[i]}, {22'h0, e.addr});
      check("pwrite", i, {31'h0, pwrite[i]}, {31'h0, e.wr});
      if (e.wr) check("pwdata", i, pwdata[i], e.wdata);
      prdata[i] = e.rdata;
    end
  endtask

  task automatic slave_step(input int i);
    prdata[i] = $urandom;
    if (!rst_n) begin
      pready[i] = 1'b0; busy[i] = 1'b0; gap_chk[i] = 1'b0;
      prev_done[i] = done[i]; prev_to[i] = timeout[i];
      return;
    end
    if (done[i] !== prev_done[i] || timeout[i] !== prev_to[i])
      check("done_timeout_edge", i, {31'h0, timeout[i]}, {31'h0, exp_to[i] & done[i]});
    prev_done[i] = done[i]; prev_to[i] = timeout[i];
    if (gap_chk[i]) begin
      check("idle_after_xfer", i, {31'h0, psel[i]}, 32'h0);
      gap_chk[i] = 1'b0;
    end
    if (psel[i] && !penable[i]) begin
      busy[i] = 1'b1;
      s_addr[i] = paddr[i]; s_wr[i] = pwrite[i]; s_wd[i] = pwdata[i];
      waits_sel[i] = force_waits ? 3 : int'($urandom_range(0, 2));
      waits_left[i] = waits_sel[i];
      en_cycles[i] = 0;
      pready[i] = 1'b0;
    end else if (psel[i] && penable[i]) begin
      check("setup_before_access", i, {31'h0, busy[i]}, 32'h1);
      en_cycles[i]++;
      check("paddr_stable", i, {22'h0, paddr[i]}, {22'h0, s_addr[i]});
      check("pwrite_stable", i, {31'h0, pwrite[i]}, {31'h0, s_wr[i]});
      check("pwdata_stable", i, pwdata[i], s_wd[i]);
      if (waits_left[i] == 0) begin
        pready[i] = 1'b1;
        complete(i);
        check("penable_cycles", i, en_cycles[i], waits_sel[i] + 1);
        gap_chk[i] = 1'b1;
        busy[i] = 1'b0;
      end else begin
        waits_left[i]--;
        pready[i] = 1'b0;
      end
    end else begin
      pready[i] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) slave_step(i);
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    q0.delete();
    q1.delete();
    @(negedge clk);
  endtask

  task automatic wait_done();
    int cyc;
    cyc = 0;
    while (!(done[0] && done[1]) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    check("done_in_budget", 0, {31'h0, done[0] & done[1]}, 32'h1);
    repeat (30) @(negedge clk);
  endtask

  task automatic final_checks();
    check("done", 0, {31'h0, done[0]}, 32'h1);
    check("done", 1, {31'h0, done[1]}, 32'h1);
    for (int i = 0; i < 2; i++) begin
      check("timeout", i, {31'h0, timeout[i]}, {31'h0, exp_to[i]});
      check("byte_cnt", i, {16'h0, byte_cnt[i]}, exp_bytes[i]);
      check("err_cnt", i, {16'h0, err_cnt[i]}, exp_err[i]);
    end
    check("queue_drained", 0, q0.size(), 0);
    check("queue_drained", 1, q1.size(), 0);
  endtask

  task automatic reset_state_checks();
    for (int i = 0; i < 2; i++) begin
      check("rst_psel", i, {31'h0, psel[i]}, 32'h0);
      check("rst_penable", i, {31'h0, penable[i]}, 32'h0);
      check("rst_pwrite", i, {31'h0, pwrite[i]}, 32'h0);
      check("rst_paddr", i, {22'h0, paddr[i]}, 32'h0);
      check("rst_pwdata", i, pwdata[i], 32'h0);
      check("rst_done", i, {31'h0, done[i]}, 32'h0);
      check("rst_timeout", i, {31'h0, timeout[i]}, 32'h0);
      check("rst_byte_cnt", i, {16'h0, byte_cnt[i]}, 32'h0);
      check("rst_err_cnt", i, {16'h0, err_cnt[i]}, 32'h0);
    end
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_state_checks();

    // Random wait states and poll counts
    plan_run(1'b0);
    rst_n = 1'b1;
    wait_done();
    final_checks();

    // Every access stretched by three wait states
    do_reset();
    reset_state_checks();
    force_waits = 1'b1;
    plan_run(1'b0);
    rst_n = 1'b1;
    wait_done();
    final_checks();
    force_waits = 1'b0;

    // Reset landing in the middle of a TX access phase
    do_reset();
    plan_run(1'b0);
    rst_n = 1'b1;
    cyc = 0;
    while (!(byte_cnt[0] >= 16'd2 && psel[0] && penable[0]) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    check("reached_mid_access", 0, {31'h0, psel[0] & penable[0]}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    reset_state_checks();
    @(negedge clk);
    @(negedge clk);
    q0.delete();
    q1.delete();
    plan_run(1'b0);
    rst_n = 1'b1;
    wait_done();
    final_checks();

    // RX never sees data: poll limit expires
    do_reset();
    plan_run(1'b1);
    rst_n = 1'b1;
    wait_done();
    final_checks();

    // One more random run after a timeout
    do_reset();
    plan_run(1'b0);
    rst_n = 1'b1;
    wait_done();
    final_checks();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
